// File: rtl/mem_responder.sv
// Word-addressed pipelined main-memory model: the responder end of the cache-to-memory interface.
// Reads return a snapshot of the addressed word exactly LATENCY cycles after the request; writes complete in one edge.
module mem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        outstanding
);

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_retire;
    logic [3:0]            w_out_nxt;
    logic [ADDR_W-1:0]     w_unused_addr;

    logic [DATA_W-1:0]     r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [LATENCY-1:0]    r_vld;
    logic [DATA_W-1:0]     r_dat [0:LATENCY-1];
    logic [3:0]            r_out;

    // Bit 0 and any bits above DEPTH_LOG2 do not select a word; addresses alias.
    assign w_idx         = addr[DEPTH_LOG2:1];
    assign w_unused_addr = addr;
    assign w_rd          = enable && !wr;
    assign w_wr          = enable && wr;
    assign w_retire      = r_vld[LATENCY-1];

    // Array is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Data stages carry no reset: they are only observed through their valid bit.
    always_ff @(posedge clk) begin
        r_dat[0] <= r_mem[w_idx];
        for (int unsigned k = 1; k < LATENCY; k++) begin
            r_dat[k] <= r_dat[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_out <= '0;
        end else begin
            r_vld[0] <= w_rd;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_out <= w_out_nxt;
        end
    end

    always_comb begin
        w_out_nxt = r_out;
        if (w_rd && !w_retire) begin
            w_out_nxt = r_out + 4'd1;
        end else if (!w_rd && w_retire) begin
            w_out_nxt = r_out - 4'd1;
        end
    end

    assign data_valid  = r_vld[LATENCY-1];
    assign data_out    = r_vld[LATENCY-1] ? r_dat[LATENCY-1] : '0;
    assign outstanding = r_out;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a per-cycle vector table for the basic scenarios,
// plus hand-written block-fill and reset-in-flight sequences.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  outstanding;

    int n_vec;
    int n_miss;

    mem_responder #(
        .ADDR_W(16),
        .DATA_W(16),
        .DEPTH_LOG2(15),
        .LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr(wr),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven in that cycle, outputs expected in that same cycle.
    typedef struct {
        logic        rst;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        chk;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rs, input logic en, input logic w,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic chk, input logic ev,
                                input logic [15:0] ed, input logic [3:0] eo);
        vec_t v;
        v.rst = rs; v.en = en; v.wr = w; v.addr = a; v.din = d;
        v.chk = chk; v.ev = ev; v.ed = ed; v.eo = eo;
        vecs.push_back(v);
    endfunction

    // Checks outputs of the current cycle at the falling edge, then drives this cycle's inputs.
    task automatic step(input logic rs, input logic en, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic chk, input logic ev,
                        input logic [15:0] ed, input logic [3:0] eo,
                        input string nm, input int idx);
        @(negedge clk);
        if (chk) begin
            n_vec++;
            if (data_valid !== ev) begin
                n_miss++;
                $display("FAIL %s[%0d] data_valid: got %0b, want %0b", nm, idx, data_valid, ev);
            end
            if (data_out !== ed) begin
                n_miss++;
                $display("FAIL %s[%0d] data_out: got %h, want %h", nm, idx, data_out, ed);
            end
            if (outstanding !== eo) begin
                n_miss++;
                $display("FAIL %s[%0d] outstanding: got %0d, want %0d", nm, idx, outstanding, eo);
            end
        end
        rst = rs; enable = en; wr = w; addr = a; data_in = d;
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;

        //   rst  en   wr   addr      din       chk  ev   ed        eo
        // reset then idle
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0);
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        // write BEEF, read one cycle later, response in cycle 5
        add(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        // read snapshot vs later write to the same word
        add(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1111, 4'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        // bubble and bit-0 aliasing: 0x0002 and 0x0003 hit one word
        add(1'b0, 1'b1, 1'b1, 16'h0002, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 4'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 4'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din,
                 vecs[i].chk, vecs[i].ev, vecs[i].ed, vecs[i].eo, "table", i);
        end

        // block fill: preload 8 words, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0040 + 16'(2*i), 16'h1000 + 16'(i),
                 1'b1, 1'b0, 16'h0000, 4'd0, "preload", i);
        end
        for (int c = 0; c <= 12; c++) begin
            int          cnt;
            logic        ev;
            logic [15:0] ed;
            cnt = 0;
            for (int r = 0; r < 8; r++) begin
                if (r + 1 <= c && c <= r + 4) cnt++;
            end
            ev = (c >= 4 && c <= 11);
            ed = ev ? 16'h1000 + 16'(c - 4) : 16'h0000;
            step(1'b0, (c < 8), 1'b0, 16'h0040 + 16'(2*c), 16'h0000,
                 1'b1, ev, ed, 4'(cnt), "fill", c);
        end

        // reset with three reads in flight; earlier write must survive
        step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 4'd0, "rstfl", 0);
        step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, "rstfl", 1);
        step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1, "rstfl", 2);
        step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd2, "rstfl", 3);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd3, "rstfl", 4);
        for (int c = 5; c <= 8; c++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, "rstfl", c);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, "rstfl", 9);
        for (int c = 10; c <= 12; c++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1, "rstfl", c);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h5A5A, 4'd1, "rstfl", 13);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, "rstfl", 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
